// File: rtl/hc193_pulse_driver.sv
// hc193_pulse_driver: generates the CPU/CPD/PL_BAR/MR waveforms for a 74HC193-style counter.
// It accepts one command at a time over valid/ready and runs that command to completion.
// It also flags carry/borrow (wrap) seen during an up/down command.
module hc193_pulse_driver #(
  parameter int unsigned LOW_CYC  = 2,
  parameter int unsigned HIGH_CYC = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [CNT_W-1:0] i_cmd_n,
  input  logic [3:0]       i_cmd_d,
  input  logic             i_tcu_bar,
  input  logic             i_tcd_bar,
  output logic             o_cpu,
  output logic             o_cpd,
  output logic             o_pl_bar,
  output logic             o_mr,
  output logic [3:0]       o_d,
  output logic             o_done,
  output logic             o_wrap
);

  localparam int unsigned MaxCyc = (LOW_CYC > HIGH_CYC) ? LOW_CYC : HIGH_CYC;
  localparam int unsigned TmrW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  // The phase timer counts down from (cycles - 1) to zero.
  localparam logic [TmrW-1:0] LowLd  = TmrW'(LOW_CYC - 1);
  localparam logic [TmrW-1:0] HighLd = TmrW'(HIGH_CYC - 1);

  localparam logic [1:0] OpUp   = 2'b00;
  localparam logic [1:0] OpDown = 2'b01;
  localparam logic [1:0] OpLoad = 2'b10;
  localparam logic [1:0] OpClr  = 2'b11;

  typedef enum logic [1:0] {StIdle, StAct, StRec, StDone} state_e;

  state_e           r_state;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_rem;
  logic [TmrW-1:0]  r_tmr;
  logic             r_ready;
  logic             r_cpu;
  logic             r_cpd;
  logic             r_pl_bar;
  logic             r_mr;
  logic [3:0]       r_d;
  logic             r_done;
  logic             r_wrap;

  logic [1:0]       w_act_op;
  logic             w_cnt_op;
  logic             w_wrap_hit;

  // The op that selects the active levels: the incoming op at handshake, else the latched op.
  always_comb begin
    w_act_op   = (r_state == StIdle) ? i_cmd_op : r_op;
    w_cnt_op   = ~i_cmd_op[1];
    w_wrap_hit = (~r_cpu & ~i_tcu_bar) | (~r_cpd & ~i_tcd_bar);
  end

  // Command FSM; every waveform output is a register updated alongside the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_op     <= OpUp;
      r_rem    <= '0;
      r_tmr    <= '0;
      r_ready  <= 1'b1;
      r_cpu    <= 1'b1;
      r_cpd    <= 1'b1;
      r_pl_bar <= 1'b1;
      r_mr     <= 1'b0;
      r_d      <= 4'h0;
      r_done   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Carry/borrow only counts while the matching count clock is held low.
      if (w_wrap_hit) begin
        r_wrap <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (i_cmd_valid) begin
            r_op    <= i_cmd_op;
            r_rem   <= i_cmd_n;
            r_wrap  <= 1'b0;
            r_ready <= 1'b0;
            r_tmr   <= LowLd;
            if (i_cmd_op == OpLoad) begin
              r_d <= i_cmd_d;
            end
            if (w_cnt_op && (i_cmd_n == '0)) begin
              // A zero-length count finishes without touching the outputs.
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state  <= StAct;
              r_cpu    <= (w_act_op != OpUp);
              r_cpd    <= (w_act_op != OpDown);
              r_pl_bar <= (w_act_op != OpLoad);
              r_mr     <= (w_act_op == OpClr);
            end
          end
        end
        StAct: begin
          if (r_tmr == '0) begin
            r_state  <= StRec;
            r_tmr    <= HighLd;
            r_cpu    <= 1'b1;
            r_cpd    <= 1'b1;
            r_pl_bar <= 1'b1;
            r_mr     <= 1'b0;
            if (!r_op[1]) begin
              r_rem <= r_rem - 1'b1;
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        StRec: begin
          if (r_tmr == '0) begin
            if (!r_op[1] && (r_rem != '0)) begin
              r_state <= StAct;
              r_tmr   <= LowLd;
              r_cpu   <= (w_act_op != OpUp);
              r_cpd   <= (w_act_op != OpDown);
            end else begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Drive the ports from the registers.
  always_comb begin
    o_cmd_ready = r_ready;
    o_cpu       = r_cpu;
    o_cpd       = r_cpd;
    o_pl_bar    = r_pl_bar;
    o_mr        = r_mr;
    o_d         = r_d;
    o_done      = r_done;
    o_wrap      = r_wrap;
  end

endmodule

// File: tb/tb_hc193_pulse_driver.sv
// Bench for hc193_pulse_driver: directed test-plan cases plus random commands.
// A 74HC193 model is driven by the DUT outputs and feeds TCU_BAR/TCD_BAR back to the DUT.
// The expected waveforms are derived from the timing rules with plain arithmetic.
module tb_hc193_pulse_driver;

  localparam int L = 2;
  localparam int H = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_n = '0;
  logic [3:0]       cmd_d = 4'h0;
  logic             tcu_bar;
  logic             tcd_bar;
  logic             cpu, cpd, pl_bar, mr, done, wrap;
  logic [3:0]       d_out;

  int n_checks = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  logic [3:0] exp_d = 4'h0;

  // External counter model.
  logic [3:0] ext_cnt = 4'h0;
  logic prev_cpu = 1'b1;
  logic prev_cpd = 1'b1;

  always #5 clk = ~clk;

  hc193_pulse_driver #(.LOW_CYC(L), .HIGH_CYC(H), .CNT_W(CNT_W)) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_op   (cmd_op),
    .i_cmd_n    (cmd_n),
    .i_cmd_d    (cmd_d),
    .i_tcu_bar  (tcu_bar),
    .i_tcd_bar  (tcd_bar),
    .o_cpu      (cpu),
    .o_cpd      (cpd),
    .o_pl_bar   (pl_bar),
    .o_mr       (mr),
    .o_d        (d_out),
    .o_done     (done),
    .o_wrap     (wrap)
  );

  assign tcu_bar = !((ext_cnt == 4'hF) && !cpu);
  assign tcd_bar = !((ext_cnt == 4'h0) && !cpd);

  always @(negedge clk) begin
    if (mr) ext_cnt <= 4'h0;
    else if (!pl_bar) ext_cnt <= d_out;
    else if (!prev_cpu && cpu) ext_cnt <= ext_cnt + 4'h1;
    else if (!prev_cpd && cpd) ext_cnt <= ext_cnt - 4'h1;
    prev_cpu <= cpu;
    prev_cpd <= cpd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue one command and check every cycle until it completes.
  task automatic run_cmd(input logic [1:0] op, input int n, input logic [3:0] d,
                         input bit hold);
    int total, per, c0, waited;
    bit w, act;
    per = L + H;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_n = CNT_W'(n);
    cmd_d = d;
    c0 = exp_cnt;
    case (op)
      2'b00: begin
        total = n * per;
        w = (c0 + n) >= 16;
        exp_cnt = (c0 + n) % 16;
      end
      2'b01: begin
        total = n * per;
        w = n > c0;
        exp_cnt = (((c0 - n) % 16) + 16) % 16;
      end
      2'b10: begin
        total = per;
        w = 1'b0;
        exp_cnt = int'(d);
        exp_d = d;
      end
      default: begin
        total = per;
        w = 1'b0;
        exp_cnt = 0;
      end
    endcase
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    for (int t = 0; t < total; t++) begin
      act = (t % per) < L;
      check("cpu", cpu, !(op == 2'b00 && act));
      check("cpd", cpd, !(op == 2'b01 && act));
      check("pl_bar", pl_bar, !(op == 2'b10 && act));
      check("mr", mr, (op == 2'b11 && act));
      check("d_busy", d_out, exp_d);
      check("done_busy", done, 0);
      check("ready_busy", cmd_ready, 0);
      if (t == 0) check("wrap_clear", wrap, 0);
      @(posedge clk);
      #1;
    end
    check("done", done, 1);
    check("ready_in_done", cmd_ready, 0);
    check("wrap", wrap, w);
    check("d_done", d_out, exp_d);
    check("cpu_idle", cpu, 1);
    check("cpd_idle", cpd, 1);
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("ready_back", cmd_ready, 1);
    check("wrap_hold", wrap, w);
    check("counter", ext_cnt, exp_cnt[3:0]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, cmd_ready, 1);
    check({tag, "_cpu"}, cpu, 1);
    check({tag, "_cpd"}, cpd, 1);
    check({tag, "_pl_bar"}, pl_bar, 1);
    check({tag, "_mr"}, mr, 0);
    check({tag, "_d"}, d_out, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_wrap"}, wrap, 0);
  endtask

  initial begin
    int op, n;
    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready_after_reset", cmd_ready, 1);

    // Test-plan directed sequence.
    run_cmd(2'b00, 3, 4'h0, 1'b0);
    run_cmd(2'b10, 0, 4'hA, 1'b0);
    run_cmd(2'b01, 12, 4'h0, 1'b0);
    run_cmd(2'b00, 0, 4'h0, 1'b0);
    run_cmd(2'b11, 5, 4'h7, 1'b0);
    run_cmd(2'b00, 5, 4'h3, 1'b1);
    run_cmd(2'b01, 0, 4'h0, 1'b0);
    run_cmd(2'b00, 20, 4'h0, 1'b0);

    // Reset in the middle of a CPU low pulse.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_n = CNT_W'(5);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("cpu_low_before_reset", cpu, 0);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("mid_reset");
    exp_d = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("no_done_after_reset", done, 0);
      check("ready_after_reset", cmd_ready, 1);
      check("cpu_after_reset", cpu, 1);
    end
    run_cmd(2'b11, 0, 4'h0, 1'b0);
    run_cmd(2'b00, 2, 4'h0, 1'b0);

    // Random commands.
    for (int i = 0; i < 30; i++) begin
      op = int'($urandom_range(0, 3));
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(14, 40))
                                      : int'($urandom_range(0, 7));
      run_cmd(2'(op), n, 4'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hc193_pulse_driver.md
# hc193_pulse_driver

- Single-clock initiator that generates the control waveforms a 74HC193-style 4-bit synchronous up/down counter consumes: CPU/CPD count pulses, PL_BAR parallel load with D data, and MR clear.
- Accepts one command at a time over a valid/ready handshake and runs it to completion.
- Sits between command logic and a dual-clock-with-clear counter, discrete or RTL.
- Also watches the counter's terminal-count outputs and flags wrap-around.

## Interface
Parameters:
- LOW_CYC, default 2: cycles each active phase lasts (CPx low, PL_BAR low, MR high); legal range ≥1.
- HIGH_CYC, default 2: cycles each recovery phase lasts (CPx high, PL_BAR high, MR low) after the active phase; legal range ≥1.
- CNT_W, default 8: width of the pulse-count field.

Ports:
- CLK  in  1  sole clock; all logic on rising edge.
- RST_BAR  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  block can accept a command; high only in IDLE.
- CMD_OP  in  2  operation: 00 count up, 01 count down, 10 load, 11 clear.
- CMD_N  in  CNT_W  number of pulses for up/down; ignored for load/clear.
- CMD_D  in  4  load data; ignored unless op = 10.
- TCU_BAR  in  1  counter terminal-count-up (carry), active low, synchronous to CLK.
- TCD_BAR  in  1  counter terminal-count-down (borrow), active low, synchronous to CLK.
- CPU  out  1  count-up clock to counter; idle high.
- CPD  out  1  count-down clock to counter; idle high.
- PL_BAR  out  1  parallel load, active low.
- MR  out  1  master reset, active high.
- D  out  4  parallel data to counter.
- DONE  out  1  one-cycle pulse when a command completes.
- WRAP  out  1  sticky: carry/borrow seen during the current or last up/down command.

## Operation
- A handshake occurs on a rising edge with CMD_VALID=1 and CMD_READY=1. On that edge the block latches op, N and data, and clears WRAP. CMD_VALID while busy is ignored.
- All waveform outputs are registered; no glitches.
- FSM states:
  - IDLE: CMD_READY=1. On handshake: up/down with N≠0 → ACT; up/down with N=0 → DONE (no pulse); load → ACT; clear → ACT.
  - ACT: active phase for LOW_CYC cycles.
    - Up: CPU=0.
    - Down: CPD=0.
    - Load: PL_BAR=0, D=latched data.
    - Clear: MR=1.
  - REC: all controls return to idle level for HIGH_CYC cycles.
    - Up/down: the remaining count decrements on entry to REC. At REC end, remaining=0 → DONE, else → ACT.
    - Load/clear: REC end → DONE.
  - DONE: DONE=1 and CMD_READY=0 for one cycle, then → IDLE.
- Only the selected count clock ever goes low; the other stays high for the whole command. PL_BAR and MR are never active during count pulses.
- D holds the last loaded value until the next load.
- WRAP is set when TCU_BAR=0 is sampled while CPU=0 (up), or when TCD_BAR=0 is sampled while CPD=0 (down). It holds until the next handshake.
- Phase timer width is sized to max(LOW_CYC, HIGH_CYC). The remaining-count register is CNT_W bits, so the maximum is 2^CNT_W−1 pulses.

## Timing
- Reset values (asserted asynchronously, immediately): state IDLE, CMD_READY=1, CPU=1, CPD=1, PL_BAR=1, MR=0, D=0, DONE=0, WRAP=0.
- Handshake on edge k → the active level appears after edge k (cycle k+1).
- Up/down, N pulses:
  - Busy for N·(LOW_CYC+HIGH_CYC) cycles, then DONE.
  - DONE is high in cycle k+1+N·(LOW_CYC+HIGH_CYC).
  - CMD_READY returns the following cycle.
- Load/clear: DONE in cycle k+1+LOW_CYC+HIGH_CYC.
- N=0: DONE in cycle k+1; no output activity.
- Counter advances on each CPx rising edge, i.e. at the ACT→REC transition.
- Back-to-back commands: the earliest next handshake is the first IDLE edge after DONE.
- Reset mid-command: outputs snap to idle levels. A CPx low→high step at reset is allowed to clock the counter once. The command is discarded with no DONE.

## Test plan
- Reset then idle: RST_BAR low mid-cycle → all outputs at reset values asynchronously; CMD_READY=1 once released.
- Up count, LOW_CYC=2, HIGH_CYC=2, N=3:
  - CPU shows exactly 3 low pulses of 2 cycles, separated by 2 high cycles; CPD stays 1.
  - DONE in cycle k+13; a model counter goes 0→3.
- Load then down:
  - Load D=4'hA → PL_BAR low 2 cycles with D=A; DONE at k+5.
  - Down N=12 → counter A→0→F→E; TCD_BAR low at 0 → WRAP=1.
  - Next handshake clears WRAP.
- Clear: op=11 → MR high 2 cycles then low 2; DONE at k+5; counter reads 0; CPU/CPD/PL_BAR stay idle.
- N=0 and busy-ignore:
  - Up with N=0 → DONE at k+1, no pulses.
  - CMD_VALID held during a 5-pulse command → no second handshake until after DONE.
- Reset mid-pulse: RST_BAR asserted while CPU=0 → CPU=1 immediately; no DONE; CMD_READY=1 after release; next command runs normally.
